// File: rtl/time_entry.sv
// time_entry: keypad time-entry controller for a three-digit BCD countdown timer.
// Collects up to three BCD digits (M:SS entry, shifting left), validates the entry on start,
// drives a one-cycle active-low parallel load into the timer chain, then waits for the chain
// to report completion.
//
// Ports
//   clk        in   system clock, rising edge
//   clrn       in   asynchronous active-low reset
//   key        in   [3:0] BCD digit, sampled when key_valid=1
//   key_valid  in   one-cycle strobe: new digit on key
//   start      in   one-cycle strobe: load entered time into the timer
//   cancel     in   one-cycle strobe: discard entry / abort cook
//   timer_done in   level from countdown chain, 1 when all digits are zero
//   sec_ones   out  [3:0] units-of-seconds load value
//   sec_tens   out  [3:0] tens-of-seconds load value
//   min_ones   out  [3:0] minutes load value
//   loadn      out  active-low load strobe, low only in LOAD
//   busy       out  1 in LOAD or RUN
//   err        out  registered one-cycle pulse on a rejected start
module time_entry (
  input  logic       clk,
  input  logic       clrn,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_done,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       loadn,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StEntry, StLoad, StRun} state_e;

  state_e     r_state, w_state_next;
  logic [3:0] r_sec_ones, w_sec_ones_next;
  logic [3:0] r_sec_tens, w_sec_tens_next;
  logic [3:0] r_min_ones, w_min_ones_next;
  logic [1:0] r_count, w_count_next;
  logic       r_cancel_pend, w_cancel_pend_next;
  logic       r_err, w_err_next;

  logic w_key_ok;
  logic w_start_ok;

  assign w_key_ok   = key_valid && (key <= 4'd9) && (r_count < 2'd3);
  // Seconds tens must be a legal mod-6 value and the entry must not be all zeros.
  assign w_start_ok = (r_sec_tens <= 4'd5) && (|{r_min_ones, r_sec_tens, r_sec_ones});

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state       <= StIdle;
      r_sec_ones    <= 4'd0;
      r_sec_tens    <= 4'd0;
      r_min_ones    <= 4'd0;
      r_count       <= 2'd0;
      r_cancel_pend <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_sec_ones    <= w_sec_ones_next;
      r_sec_tens    <= w_sec_tens_next;
      r_min_ones    <= w_min_ones_next;
      r_count       <= w_count_next;
      r_cancel_pend <= w_cancel_pend_next;
      r_err         <= w_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_sec_ones_next    = r_sec_ones;
    w_sec_tens_next    = r_sec_tens;
    w_min_ones_next    = r_min_ones;
    w_count_next       = r_count;
    w_cancel_pend_next = 1'b0;
    w_err_next         = 1'b0;

    case (r_state)
      StIdle, StEntry: begin
        // cancel > start > key_valid; the losing events are simply dropped.
        if (cancel) begin
          w_state_next    = StIdle;
          w_sec_ones_next = 4'd0;
          w_sec_tens_next = 4'd0;
          w_min_ones_next = 4'd0;
          w_count_next    = 2'd0;
        end else if (start) begin
          if (r_state == StEntry) begin
            if (w_start_ok) begin
              w_state_next = StLoad;
            end else begin
              w_err_next = 1'b1;
            end
          end
        end else if (w_key_ok) begin
          w_min_ones_next = r_sec_tens;
          w_sec_tens_next = r_sec_ones;
          w_sec_ones_next = key;
          w_count_next    = r_count + 2'd1;
          w_state_next    = StEntry;
        end
      end
      StLoad: begin
        // A cancel during the load strobe is honoured one cycle later, from RUN.
        w_state_next       = StRun;
        w_cancel_pend_next = cancel;
      end
      StRun: begin
        if (cancel || r_cancel_pend || timer_done) begin
          w_state_next    = StIdle;
          w_sec_ones_next = 4'd0;
          w_sec_tens_next = 4'd0;
          w_min_ones_next = 4'd0;
          w_count_next    = 2'd0;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign sec_ones = r_sec_ones;
  assign sec_tens = r_sec_tens;
  assign min_ones = r_min_ones;
  assign loadn    = (r_state != StLoad);
  assign busy     = (r_state == StLoad) || (r_state == StRun);
  assign err      = r_err;

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 The block SHALL have the following ports (name  direction  width  meaning), clock and reset first:
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 clrn  in  1  reset, asynchronous, active-low.
REQ-004 key  in  4  BCD digit from the keypad encoder; sampled only when key_valid=1.
REQ-005 key_valid  in  1  one-cycle strobe marking key as a new digit.
REQ-006 start  in  1  one-cycle strobe requesting that the entered time be loaded into the timer chain.
REQ-007 cancel  in  1  one-cycle strobe that discards the entry or aborts a running cook.
REQ-008 timer_done  in  1  level from the countdown chain; 1 when all timer digits are zero.
REQ-009 sec_ones  out  4  BCD units-of-seconds load value (data input of the units counter).
REQ-010 sec_tens  out  4  BCD tens-of-seconds load value (data input of the mod-6 counter).
REQ-011 min_ones  out  4  BCD minutes load value (data input of the minutes counter).
REQ-012 loadn  out  1  active-low parallel-load strobe to every timer counter.
REQ-013 busy  out  1  1 while a cook is loaded or running (states LOAD and RUN).
REQ-014 err  out  1  one-cycle pulse flagging a rejected start.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ENTRY, LOAD and RUN.
REQ-016 Digit shift in IDLE or ENTRY, on key_valid=1 with key<=9 and fewer than 3 digits held: min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key, digit count +1, next state ENTRY.
REQ-017 Key values 10-15 SHALL be ignored; registers, count and state are unchanged.
REQ-018 A key_valid arriving when 3 digits are already held SHALL be ignored (no shift, no wrap).
REQ-019 key_valid in LOAD or RUN SHALL be ignored.
REQ-020 Start check, on start=1 in ENTRY: if sec_tens<=5 and any digit is nonzero, next state LOAD; otherwise err=1 for one cycle and the state stays ENTRY with registers kept.
REQ-021 start in IDLE SHALL do nothing (no err pulse).
REQ-022 LOAD SHALL last exactly one cycle with loadn=0, then go unconditionally to RUN.
REQ-023 loadn SHALL be 1 in every state other than LOAD.
REQ-024 sec_ones, sec_tens and min_ones SHALL hold stable through LOAD and RUN.
REQ-025 In RUN, timer_done=1 SHALL move the FSM to IDLE, clear the digit registers and clear the count.
REQ-026 timer_done SHALL be ignored outside RUN, including during the LOAD cycle.
REQ-027 Cancel: cancel=1 in ENTRY or RUN SHALL move the FSM to IDLE and clear the registers and count; in LOAD it SHALL take effect on the following cycle (in RUN).
REQ-028 Priority for events in the same cycle SHALL be cancel > start > key_valid; a lower-priority event in that cycle is dropped.
REQ-029 busy SHALL be combinational from state (1 in LOAD or RUN, 0 otherwise); err is a registered pulse.

Reset
REQ-030 While clrn=0, regardless of clk: state=IDLE, all digit registers=0, digit count=0, loadn=1, busy=0, err=0.
REQ-031 Reset asserted mid-entry or mid-RUN SHALL abort immediately with no loadn pulse.
REQ-032 After clrn deasserts, normal operation SHALL begin on the next rising edge of clk.

Verification
REQ-033 The bench SHALL drive keys 1, 3, 0 then start -> min_ones=1, sec_tens=3, sec_ones=0; loadn=0 for exactly 1 cycle; busy=1; timer_done=1 -> IDLE, outputs 0.
REQ-034 The bench SHALL drive keys 0, 7, 5 then start -> err=1 for 1 cycle; loadn stays 1; state stays ENTRY.
REQ-035 The bench SHALL drive keys 4, 2, 9, 8 -> the fourth key is dropped; min_ones=4, sec_tens=2, sec_ones=9.
REQ-036 The bench SHALL drive key=12 with key_valid -> no change; then key_valid, start and cancel in the same cycle -> IDLE, no loadn, no err.
REQ-037 The bench SHALL drive keys 5 and start, then pulse clrn low during RUN -> outputs 0, busy=0, loadn=1 immediately, without waiting for clk.
REQ-038 The bench SHALL drive only start while in IDLE -> no err pulse, no loadn pulse, state stays IDLE.
